div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2 bits, type div_op_t: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 The block SHALL have port dividend, input, DATA_WIDTH bits: the ALU operand 1 value.
REQ-007 The block SHALL have port divisor, input, DATA_WIDTH bits: the ALU operand 2 value.
REQ-008 The block SHALL have port flush, input, 1 bit: abort the operation in progress.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-011 The block SHALL have port result, output, DATA_WIDTH bits: quotient or remainder as selected by op.

Function
REQ-012 The state machine SHALL use states IDLE, CALC, DONE: IDLE->CALC on start, CALC->DONE after DATA_WIDTH iterations, DONE->IDLE unconditionally.
REQ-013 In IDLE with start=1, the block SHALL register op, dividend, divisor and the operand signs on that edge.
REQ-014 For DIV and REM, the block SHALL convert operands to magnitudes; DIVU and REMU SHALL use them unmodified.
REQ-015 CALC SHALL perform one restoring shift-subtract step per cycle, MSB first, driven by a counter running 0..DATA_WIDTH-1.
REQ-016 For a normal operation, start sampled at edge N SHALL give done=1 during the cycle after edge N+DATA_WIDTH+1 (33 cycles for DATA_WIDTH=32).
REQ-017 For a signed quotient, the block SHALL negate the quotient when the operand signs differ; a signed remainder SHALL take the sign of the dividend.
REQ-018 With divisor=0, the block SHALL skip CALC (IDLE->DONE, done one cycle after start) and return quotient all-ones and remainder = dividend.
REQ-019 For DIV/REM with dividend = most-negative value and divisor = -1, the block SHALL skip CALC and return quotient = dividend and remainder = 0.
REQ-020 The block SHALL ignore start while busy=1; it SHALL NOT queue it.
REQ-021 flush=1 in CALC or DONE SHALL force IDLE at the next edge, and done SHALL be 0 in that cycle and afterwards.
REQ-022 When flush=1 and start=1 in IDLE in the same cycle, flush SHALL win and the start SHALL be dropped.
REQ-023 result SHALL hold its last value from DONE until the next DONE; its value is defined only while done=1.
REQ-024 Intermediate arithmetic SHALL use a DATA_WIDTH+1-bit partial remainder so the subtract borrow is exact.

Reset
REQ-025 rst=1 SHALL force IDLE, busy=0, done=0, result=0, counter=0 immediately, independent of clk.
REQ-026 rst asserted mid-CALC SHALL discard the operation; no done pulse SHALL follow its release.
REQ-027 The first start SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-028 div_op_t and the DIV/DIVU/REM/REMU encodings SHALL live in the shared core package alongside the other ALU op types.
REQ-029 The state enum SHALL be local to div_unit.
REQ-030 div_unit SHALL be a single module with no sub-modules; the step datapath is inline.

Verification
REQ-031 Scenario: DIVU 100/7 -> done after exactly 33 cycles, result=14; REMU 100/7 -> result=2.
REQ-032 Scenario: DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
REQ-033 Scenario: DIVU 5/0 -> done 1 cycle after start, result 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-034 Scenario: DIV 0x80000000/0xFFFFFFFF -> done 1 cycle after start, result 0x80000000; REM same operands -> 0.
REQ-035 Scenario: flush at CALC cycle 10 -> busy=0 next cycle, no done pulse; a start 2 cycles later completes correctly.
REQ-036 Scenario: rst at CALC cycle 5 and start held high while busy -> immediate IDLE with no done, and the held start is ignored until busy=0.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared core package: ALU operation encodings used across the execute stage.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package div_unit_pkg;

   // Divider operation select, as decoded from the instruction.
   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   // Single-cycle ALU operations that share the execute stage with the divider.
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_SRA = 3'd7
   } alu_op_t;

   // DIV and REM treat operands as two's complement.
   function automatic logic div_is_signed(input div_op_t op);
      return ~op[0];
   endfunction

   // REM and REMU return the remainder instead of the quotient.
   function automatic logic div_is_rem(input div_op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Latency: done pulses DATA_WIDTH+1 cycles after start; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: start is accepted only while idle (busy=0); starts seen while busy are dropped, not queued.
// Ports: clk/rst (async active-high), start/op/dividend/divisor request, flush abort,
//        busy (not idle), done (one-cycle result-valid pulse), result (quotient or remainder).
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  div_op_t               op,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     quo;       // dividend magnitude shifting out, quotient shifting in
   logic [W:0]       rem;       // partial remainder, one extra bit for an exact borrow
   logic [W-1:0]     dvs;       // divisor magnitude
   logic             neg_quo;
   logic             neg_rem;
   logic             sel_rem;

   // Request decode, only meaningful while idle.
   logic         op_signed;
   logic         a_neg, b_neg;
   logic         div_zero, sgn_ovf;
   logic         accept, last;
   logic [W-1:0] mag_a, mag_b;
   logic [W-1:0] most_neg;

   assign most_neg  = {1'b1, {(W-1){1'b0}}};
   assign op_signed = div_is_signed(op);
   assign a_neg     = op_signed & dividend[W-1];
   assign b_neg     = op_signed & divisor[W-1];
   assign mag_a     = a_neg ? -dividend : dividend;
   assign mag_b     = b_neg ? -divisor  : divisor;
   assign div_zero  = (divisor == '0);
   assign sgn_ovf   = op_signed & (dividend == most_neg) & (divisor == '1);
   assign accept    = (state == IDLE) & start & ~flush;
   assign last      = (cnt == CNT_W'(W - 1));

   // One restoring step: shift the next dividend bit in, subtract if it fits.
   logic [W:0] rem_sh, rem_sub;
   assign rem_sh  = {rem[W-1:0], quo[W-1]};
   assign rem_sub = rem_sh - {1'b0, dvs};

   // Sign fix-up applied once, on the way out.
   logic [W-1:0] quo_fix, rem_fix;
   assign quo_fix = neg_quo ? -quo : quo;
   assign rem_fix = neg_rem ? -rem[W-1:0] : rem[W-1:0];

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (div_zero | sgn_ovf) ? DONE : CALC;
         CALC: begin
            if (flush)     state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         quo     <= '0;
         rem     <= '0;
         dvs     <= '0;
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
         sel_rem <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt     <= '0;
                  sel_rem <= div_is_rem(op);
                  dvs     <= mag_b;
                  if (div_zero) begin
                     // Quotient all-ones, remainder is the raw dividend: no fix-up.
                     quo     <= '1;
                     rem     <= {1'b0, dividend};
                     neg_quo <= 1'b0;
                     neg_rem <= 1'b0;
                  end else if (sgn_ovf) begin
                     // MIN / -1 overflows: quotient wraps back to MIN, remainder 0.
                     quo     <= dividend;
                     rem     <= '0;
                     neg_quo <= 1'b0;
                     neg_rem <= 1'b0;
                  end else begin
                     quo     <= mag_a;
                     rem     <= '0;
                     neg_quo <= a_neg ^ b_neg;
                     neg_rem <= a_neg;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  cnt <= '0;
               end else begin
                  cnt <= last ? '0 : cnt + 1'b1;
                  if (!rem_sub[W]) begin
                     rem <= rem_sub;
                     quo <= {quo[W-2:0], 1'b1};
                  end else begin
                     rem <= rem_sh;
                     quo <= {quo[W-2:0], 1'b0};
                  end
               end
            end
            DONE: begin
               if (!flush) begin
                  done   <= 1'b1;
                  result <= sel_rem ? rem_fix : quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (DATA_WIDTH = 32).
// Latency counts are cycles from the edge that samples start to the first cycle with done high.
// All inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_div_unit;
   import div_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   div_op_t     op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   div_unit #(.DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .dividend (dividend),
      .divisor  (divisor),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Issue one operation and wait (bounded) for done; lat = -1 on timeout.
   task automatic run_op(input div_op_t o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      op       = o;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = -1;
      res   = 32'hDEAD_BEEF;
      for (int i = 1; i <= 100; i++) begin
         if (i > 1 || !done) begin
            @(posedge clk); #1;
         end
         if (done) begin
            lat = i;
            res = result;
            break;
         end
      end
   endtask

   // Count done pulses over a window of cycles.
   task automatic count_done(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = DIV; dividend = '0; divisor = '0;
      #2;
      n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned();
      logic [31:0] res; int lat; int seen;
      run_op(DIVU, 32'd100, 32'd7, res, lat);
      n_checks++; if (lat !== 33)      begin n_fail++; $display("FAIL divu_latency: got %0d want 33", lat); end
      n_checks++; if (res !== 32'd14)  begin n_fail++; $display("FAIL divu_100_7: got %h want 0000000e", res); end
      n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL busy_at_done: got %b want 0", busy); end
      count_done(1, seen);
      n_checks++; if (seen !== 0)      begin n_fail++; $display("FAIL done_one_cycle: got %0d extra pulses want 0", seen); end
      run_op(REMU, 32'd100, 32'd7, res, lat);
      n_checks++; if (res !== 32'd2)   begin n_fail++; $display("FAIL remu_100_7: got %h want 00000002", res); end
      run_op(DIVU, 32'hFFFF_FFFF, 32'h10, res, lat);
      n_checks++; if (res !== 32'h0FFF_FFFF) begin n_fail++; $display("FAIL divu_max_16: got %h want 0fffffff", res); end
      run_op(REMU, 32'hFFFF_FFFF, 32'h10, res, lat);
      n_checks++; if (res !== 32'hF)   begin n_fail++; $display("FAIL remu_max_16: got %h want 0000000f", res); end
   endtask

   task automatic test_signed();
      logic [31:0] res; int lat;
      run_op(DIV, 32'hFFFF_FFF9, 32'd2, res, lat);
      n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2: got %h want fffffffd", res); end
      n_checks++; if (lat !== 33)            begin n_fail++; $display("FAIL div_latency: got %0d want 33", lat); end
      run_op(REM, 32'hFFFF_FFF9, 32'd2, res, lat);
      n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_m7_2: got %h want ffffffff", res); end
      run_op(REM, 32'd7, 32'hFFFF_FFFE, res, lat);
      n_checks++; if (res !== 32'd1)         begin n_fail++; $display("FAIL rem_7_m2: got %h want 00000001", res); end
      run_op(DIV, 32'd7, 32'hFFFF_FFFE, res, lat);
      n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7_m2: got %h want fffffffd", res); end
      run_op(DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, res, lat);
      n_checks++; if (res !== 32'd3)         begin n_fail++; $display("FAIL div_m7_m2: got %h want 00000003", res); end
   endtask

   task automatic test_div_zero();
      logic [31:0] res; int lat;
      run_op(DIVU, 32'd5, 32'd0, res, lat);
      n_checks++; if (lat !== 1)             begin n_fail++; $display("FAIL div0_latency: got %0d want 1", lat); end
      n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_5_0: got %h want ffffffff", res); end
      run_op(REMU, 32'd5, 32'd0, res, lat);
      n_checks++; if (res !== 32'd5)         begin n_fail++; $display("FAIL remu_5_0: got %h want 00000005", res); end
      run_op(REM, 32'hFFFF_FFF9, 32'd0, res, lat);
      n_checks++; if (res !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL rem_m7_0: got %h want fffffff9", res); end
   endtask

   task automatic test_overflow();
      logic [31:0] res; int lat;
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
      n_checks++; if (lat !== 1)             begin n_fail++; $display("FAIL ovf_latency: got %0d want 1", lat); end
      n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf: got %h want 80000000", res); end
      run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
      n_checks++; if (res !== 32'd0)         begin n_fail++; $display("FAIL rem_ovf: got %h want 00000000", res); end
      run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
      n_checks++; if (res !== 32'd0)         begin n_fail++; $display("FAIL divu_no_ovf: got %h want 00000000", res); end
      n_checks++; if (lat !== 33)            begin n_fail++; $display("FAIL divu_no_ovf_latency: got %0d want 33", lat); end
   endtask

   task automatic test_flush();
      logic [31:0] res; int lat; int seen;
      op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_calc: got %b want 1", busy); end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b want 0", done); end
      @(posedge clk); #1;
      run_op(DIVU, 32'd1000, 32'd10, res, lat);
      n_checks++; if (res !== 32'd100) begin n_fail++; $display("FAIL after_flush_result: got %h want 00000064", res); end
      n_checks++; if (lat !== 33)      begin n_fail++; $display("FAIL after_flush_latency: got %0d want 33", lat); end
      // flush and start together in IDLE: start dropped
      op = DIVU; dividend = 32'd9; divisor = 32'd3; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b want 0", busy); end
      count_done(40, seen);
      n_checks++; if (seen !== 0)    begin n_fail++; $display("FAIL flush_start_done: got %0d pulses want 0", seen); end
   endtask

   task automatic test_back_to_back();
      int seen; int lat; logic [31:0] res;
      // start held high for the whole operation; operands change mid-flight
      op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      dividend = 32'd50;
      lat = -1; res = '0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (done) begin lat = i; res = result; break; end
      end
      start = 1'b0;
      n_checks++; if (lat !== 33)     begin n_fail++; $display("FAIL held_start_latency: got %0d want 33", lat); end
      n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL held_start_result: got %h want 0000000e", res); end
      count_done(40, seen);
      n_checks++; if (seen !== 0)     begin n_fail++; $display("FAIL held_start_queued: got %0d pulses want 0", seen); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] res;
      op = DIV; dividend = 32'd200; divisor = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      repeat (5) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_done: got %b want 0", done); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL mid_rst_result: got %h want 0", result); end
      // new request waiting with start high as reset releases
      op = DIVU; dividend = 32'd9; divisor = 32'd3;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_start_accepted: got busy %b want 1", busy); end
      lat = -1; res = '0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (done) begin lat = i; res = result; break; end
      end
      n_checks++; if (lat !== 33)    begin n_fail++; $display("FAIL post_rst_latency: got %0d want 33", lat); end
      n_checks++; if (res !== 32'd3) begin n_fail++; $display("FAIL post_rst_result: got %h want 00000003", res); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
